// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I opcode, ALU-op and class definitions for control and encoder paths
package riscv_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] F7_00 = 7'h00;
  localparam logic [6:0] F7_20 = 7'h20;
  typedef enum logic [2:0] {
    CLS_LOAD   = 3'd0,
    CLS_STORE  = 3'd1,
    CLS_BRANCH = 3'd2,
    CLS_RTYPE  = 3'd3,
    CLS_ITYPE  = 3'd4
  } instr_class_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} load_state_t;
  // returns {funct7, funct3} for an ALU op; out-of-range ops map to zero
  function automatic logic [9:0] alu_f7f3(input logic [3:0] op);
    logic [9:0] r;
    r = '0;
    case (op)
      ALU_ADD:  r = {F7_00, 3'b000};
      ALU_SUB:  r = {F7_20, 3'b000};
      ALU_SLL:  r = {F7_00, 3'b001};
      ALU_SLT:  r = {F7_00, 3'b010};
      ALU_SLTU: r = {F7_00, 3'b011};
      ALU_XOR:  r = {F7_00, 3'b100};
      ALU_SRL:  r = {F7_00, 3'b101};
      ALU_SRA:  r = {F7_20, 3'b101};
      ALU_OR:   r = {F7_00, 3'b110};
      ALU_AND:  r = {F7_00, 3'b111};
      default:  r = '0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/instr_word_encoder.sv
// instr_word_encoder: packs one abstract instruction beat into an RV32I word and flags illegal beats
module instr_word_encoder
  import riscv_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [3:0]  aluop,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word,
  output logic        illegal
);
  logic [9:0] f7f3;
  logic [6:0] f7;
  logic [2:0] af3;
  logic       alu_bad;
  logic       is_shift;
  assign f7f3     = alu_f7f3(aluop);
  assign f7       = f7f3[9:3];
  assign af3      = f7f3[2:0];
  assign alu_bad  = aluop > ALU_SLTU;
  assign is_shift = aluop == ALU_SLL || aluop == ALU_SRL || aluop == ALU_SRA;
  // branch imm carries offset[12:1]: imm[11]=b12, imm[10]=b11, imm[9:4]=b10:5, imm[3:0]=b4:1
  always_comb begin
    word    = '0;
    illegal = 1'b1;
    case (cls)
      CLS_LOAD: begin
        word    = {imm, rs1, funct3, rd, OP_LOAD};
        illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      CLS_STORE: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
      end
      CLS_BRANCH: begin
        word    = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], OP_BRANCH};
        illegal = funct3 == 3'b010 || funct3 == 3'b011;
      end
      CLS_RTYPE: begin
        word    = {f7, rs2, rs1, af3, rd, OP_RTYPE};
        illegal = alu_bad;
      end
      CLS_ITYPE: begin
        word    = is_shift ? {f7, imm[4:0], rs1, af3, rd, OP_ITYPE} : {imm, rs1, af3, rd, OP_ITYPE};
        illegal = alu_bad || aluop == ALU_SUB;
      end
      default: begin
        word    = '0;
        illegal = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: streams encoded RV32I words into instruction memory at sequential addresses
module instr_encoder_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-3:0] prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [3:0]        in_aluop,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err_illegal,
  output logic [ADDR_W-3:0] words_written
);
  load_state_t       state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-3:0] len_q;
  logic [ADDR_W-3:0] ww_inc;
  logic [31:0]       word;
  logic              illegal;
  logic              fire;
  logic              wr;
  logic              load;
  instr_word_encoder u_enc (
    .cls     (in_class),
    .aluop   (in_aluop),
    .funct3  (in_funct3),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (word),
    .illegal (illegal)
  );
  assign in_ready = state == S_RUN;
  assign done     = state == S_DONE;
  assign fire     = in_valid && in_ready;
  assign wr       = fire && !illegal;
  assign load     = start && state != S_RUN;
  assign ww_inc   = words_written + (ADDR_W-2)'(1);
  always_comb begin
    state_n = state;
    if (load)
      state_n = prog_len == '0 ? S_DONE : S_RUN;
    else if (wr && ww_inc == len_q)
      state_n = S_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      len_q         <= '0;
      words_written <= '0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      err_illegal   <= 1'b0;
    end else begin
      imem_we <= wr;
      if (load) begin
        ptr           <= {base_addr[ADDR_W-1:2], 2'b00};
        len_q         <= prog_len;
        words_written <= '0;
        err_illegal   <= 1'b0;
      end
      if (wr) begin
        ptr           <= ptr + ADDR_W'(4);
        words_written <= ww_inc;
        imem_addr     <= ptr;
        imem_wdata    <= word;
      end
      if (fire && illegal) err_illegal <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed self-checking bench for the instruction encoder/loader
module tb_instr_encoder_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] base_addr;
  logic [9:0]  prog_len;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [3:0]  in_aluop;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [11:0] in_imm;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        done;
  logic        err_illegal;
  logic [9:0]  words_written;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .prog_len(prog_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class), .in_aluop(in_aluop),
    .in_funct3(in_funct3), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .done(done),
    .err_illegal(err_illegal), .words_written(words_written)
  );

  task automatic do_start(input logic [11:0] b, input logic [9:0] l);
    start = 1'b1; base_addr = b; prog_len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic set_beat(input logic [2:0] c, input logic [3:0] op, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [11:0] imm);
    in_class = c; in_aluop = op; in_funct3 = f3; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic send(input logic [2:0] c, input logic [3:0] op, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [11:0] imm);
    set_beat(c, op, f3, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; base_addr = '0; prog_len = '0; in_valid = 1'b0;
    set_beat(3'd0, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", imem_we); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_illegal); end
    total++; if (imem_addr !== 12'h000) begin bad++; $display("FAIL reset_addr got=%h exp=000", imem_addr); end
    total++; if (imem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", imem_wdata); end
    total++; if (words_written !== 10'd0) begin bad++; $display("FAIL reset_ww got=%0d exp=0", words_written); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rtype;
    do_start(12'h100, 10'd2);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rtype_ready got=%b exp=1", in_ready); end
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL rtype_we_before got=%b exp=0", imem_we); end
    send(3'd3, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 12'd0);
    total++; if (imem_we !== 1'b1) begin bad++; $display("FAIL rtype_add_we got=%b exp=1", imem_we); end
    total++; if (imem_addr !== 12'h100) begin bad++; $display("FAIL rtype_add_addr got=%h exp=100", imem_addr); end
    total++; if (imem_wdata !== 32'h002081B3) begin bad++; $display("FAIL rtype_add_data got=%h exp=002081b3", imem_wdata); end
    total++; if (words_written !== 10'd1) begin bad++; $display("FAIL rtype_add_ww got=%0d exp=1", words_written); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rtype_add_done got=%b exp=0", done); end
    send(3'd3, 4'd1, 3'd0, 5'd3, 5'd1, 5'd2, 12'd0);
    total++; if (imem_wdata !== 32'h402081B3) begin bad++; $display("FAIL rtype_sub_data got=%h exp=402081b3", imem_wdata); end
    total++; if (imem_addr !== 12'h104) begin bad++; $display("FAIL rtype_sub_addr got=%h exp=104", imem_addr); end
    total++; if (done !== 1'b1 || in_ready !== 1'b0 || imem_we !== 1'b1) begin bad++; $display("FAIL rtype_final got=done%b/rdy%b/we%b exp=1/0/1", done, in_ready, imem_we); end
    @(posedge clk); #1;
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL rtype_idle_we got=%b exp=0", imem_we); end
    total++; if (imem_wdata !== 32'h402081B3 || imem_addr !== 12'h104) begin bad++; $display("FAIL rtype_hold got=%h@%h exp=402081b3@104", imem_wdata, imem_addr); end
    total++; if (words_written !== 10'd2) begin bad++; $display("FAIL rtype_ww got=%0d exp=2", words_written); end
  endtask

  task automatic test_back_to_back;
    do_start(12'h000, 10'd2);
    send(3'd0, 4'd0, 3'b010, 5'd5, 5'd1, 5'd0, 12'd8);
    total++; if (imem_we !== 1'b1 || imem_addr !== 12'h000 || imem_wdata !== 32'h0080A283) begin bad++; $display("FAIL b2b_load got=%b %h@%h exp=1 0080a283@000", imem_we, imem_wdata, imem_addr); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_load_done got=%b exp=0", done); end
    send(3'd1, 4'd0, 3'b010, 5'd0, 5'd1, 5'd2, 12'd4);
    total++; if (imem_we !== 1'b1 || imem_addr !== 12'h004 || imem_wdata !== 32'h0020A223) begin bad++; $display("FAIL b2b_store got=%b %h@%h exp=1 0020a223@004", imem_we, imem_wdata, imem_addr); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", done); end
  endtask

  task automatic test_itype_branch;
    do_start(12'h200, 10'd2);
    send(3'd4, 4'd7, 3'd0, 5'd4, 5'd4, 5'd0, 12'hFE3);
    total++; if (imem_wdata !== 32'h40325213 || imem_addr !== 12'h200) begin bad++; $display("FAIL itype_sra got=%h@%h exp=40325213@200", imem_wdata, imem_addr); end
    send(3'd2, 4'd0, 3'b000, 5'd0, 5'd1, 5'd2, 12'd4);
    total++; if (imem_wdata !== 32'h00208463 || imem_addr !== 12'h204) begin bad++; $display("FAIL branch got=%h@%h exp=00208463@204", imem_wdata, imem_addr); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ib_done got=%b exp=1", done); end
  endtask

  task automatic test_illegal;
    do_start(12'h040, 10'd2);
    send(3'd4, 4'd1, 3'd0, 5'd1, 5'd0, 5'd0, 12'd5);
    total++; if (imem_we !== 1'b0 || err_illegal !== 1'b1 || words_written !== 10'd0) begin bad++; $display("FAIL ill_isub got=we%b err%b ww%0d exp=0/1/0", imem_we, err_illegal, words_written); end
    send(3'd4, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 12'd5);
    total++; if (imem_we !== 1'b1 || imem_wdata !== 32'h00500093 || imem_addr !== 12'h040) begin bad++; $display("FAIL ill_addi got=%b %h@%h exp=1 00500093@040", imem_we, imem_wdata, imem_addr); end
    send(3'd3, 4'd12, 3'd0, 5'd6, 5'd7, 5'd8, 12'd0);
    total++; if (imem_we !== 1'b0 || words_written !== 10'd1) begin bad++; $display("FAIL ill_aluop got=we%b ww%0d exp=0/1", imem_we, words_written); end
    send(3'd6, 4'd0, 3'd0, 5'd6, 5'd7, 5'd8, 12'd0);
    total++; if (imem_we !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL ill_class got=we%b rdy%b exp=0/1", imem_we, in_ready); end
    send(3'd1, 4'd0, 3'b100, 5'd0, 5'd7, 5'd8, 12'd0);
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL ill_store_f3 got=%b exp=0", imem_we); end
    send(3'd2, 4'd0, 3'b011, 5'd0, 5'd7, 5'd8, 12'd0);
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL ill_branch_f3 got=%b exp=0", imem_we); end
    send(3'd3, 4'd4, 3'd0, 5'd6, 5'd7, 5'd8, 12'd0);
    total++; if (imem_we !== 1'b1 || imem_wdata !== 32'h0083F333 || imem_addr !== 12'h044) begin bad++; $display("FAIL ill_and got=%b %h@%h exp=1 0083f333@044", imem_we, imem_wdata, imem_addr); end
    total++; if (done !== 1'b1 || err_illegal !== 1'b1 || words_written !== 10'd2) begin bad++; $display("FAIL ill_end got=done%b err%b ww%0d exp=1/1/2", done, err_illegal, words_written); end
  endtask

  task automatic test_wrap;
    do_start(12'hFFE, 10'd2);
    total++; if (err_illegal !== 1'b0 || words_written !== 10'd0) begin bad++; $display("FAIL wrap_start_clear got=err%b ww%0d exp=0/0", err_illegal, words_written); end
    send(3'd4, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 12'd5);
    total++; if (imem_addr !== 12'hFFC || imem_wdata !== 32'h00500093) begin bad++; $display("FAIL wrap_first got=%h@%h exp=00500093@ffc", imem_wdata, imem_addr); end
    send(3'd3, 4'd4, 3'd0, 5'd6, 5'd7, 5'd8, 12'd0);
    total++; if (imem_addr !== 12'h000 || imem_we !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL wrap_second got=we%b @%h done%b exp=1 @000 1", imem_we, imem_addr, done); end
  endtask

  task automatic test_zero_len;
    set_beat(3'd4, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 12'd5);
    in_valid = 1'b1;
    do_start(12'h080, 10'd0);
    total++; if (done !== 1'b1 || imem_we !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL zero_len got=done%b we%b rdy%b exp=1/0/0", done, imem_we, in_ready); end
    @(posedge clk); #1;
    total++; if (imem_we !== 1'b0 || words_written !== 10'd0 || imem_addr !== 12'h000) begin bad++; $display("FAIL zero_len_hold got=we%b ww%0d @%h exp=0/0/000", imem_we, words_written, imem_addr); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midload;
    do_start(12'h300, 10'd4);
    set_beat(3'd4, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 12'd5);
    in_valid = 1'b1;
    @(posedge clk); #1;
    total++; if (imem_we !== 1'b1 || imem_addr !== 12'h300) begin bad++; $display("FAIL mid_pre got=we%b @%h exp=1 @300", imem_we, imem_addr); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (imem_we !== 1'b0 || imem_addr !== 12'h000 || imem_wdata !== 32'h0 || words_written !== 10'd0) begin bad++; $display("FAIL mid_rst got=we%b %h@%h ww%0d exp=0 0@000 0", imem_we, imem_wdata, imem_addr, words_written); end
    total++; if (in_ready !== 1'b0 || done !== 1'b0 || err_illegal !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl got=rdy%b done%b err%b exp=0/0/0", in_ready, done, err_illegal); end
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b0 || imem_we !== 1'b0) begin bad++; $display("FAIL mid_after got=rdy%b we%b exp=0/0", in_ready, imem_we); end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_back_to_back;
    test_itype_branch;
    test_illegal;
    test_wrap;
    test_zero_len;
    test_reset_midload;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
